// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass, optional hardwired zero
// register, registered debug port and a per-register busy scoreboard for issue.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  input  logic                  read_use_1,
  input  logic                  read_use_2,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic                  issue_valid,
  input  logic                  issue_dest_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_count,
  input  logic [ADDR_WIDTH-1:0] read_address_debug,
  output logic [DATA_WIDTH-1:0] data_out_debug
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] registers [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [CNT_W-1:0]      pending_next;

  logic wr_commit;
  logic write_hit_1;
  logic write_hit_2;
  logic write_hit_dest;
  logic eff_busy_1;
  logic eff_busy_2;
  logic eff_busy_dest;
  logic set_fire;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Read ports with same-cycle writeback bypass.
  always_comb begin
    wr_commit      = write_enable & ~is_zero(write_address);
    write_hit_1    = write_enable && (write_address == read_address_1);
    write_hit_2    = write_enable && (write_address == read_address_2);
    write_hit_dest = write_enable && (write_address == issue_dest);

    if (is_zero(read_address_1)) begin
      data_out_1 = '0;
    end else if (write_hit_1) begin
      data_out_1 = write_data_in;
    end else begin
      data_out_1 = registers[read_address_1];
    end

    if (is_zero(read_address_2)) begin
      data_out_2 = '0;
    end else if (write_hit_2) begin
      data_out_2 = write_data_in;
    end else begin
      data_out_2 = registers[read_address_2];
    end
  end

  // Hazard detection: an in-flight writeback hides the busy bit it clears.
  always_comb begin
    eff_busy_1    = busy[read_address_1] & ~write_hit_1;
    eff_busy_2    = busy[read_address_2] & ~write_hit_2;
    eff_busy_dest = busy[issue_dest] & ~write_hit_dest;
    stall         = issue_valid & ((read_use_1 & eff_busy_1) |
                                   (read_use_2 & eff_busy_2) |
                                   (issue_dest_valid & eff_busy_dest));
    set_fire      = issue_valid & issue_dest_valid & ~stall & ~is_zero(issue_dest);
  end

  // Scoreboard next state; a new producer's set overrides the old writeback's clear.
  always_comb begin
    busy_next = busy;
    if (write_enable) begin
      busy_next[write_address] = 1'b0;
    end
    if (set_fire) begin
      busy_next[issue_dest] = 1'b1;
    end
    pending_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pending_next = pending_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        registers[i] <= '0;
      end
      busy           <= '0;
      pending_count  <= '0;
      data_out_debug <= '0;
    end else begin
      if (wr_commit) begin
        registers[write_address] <= write_data_in;
      end
      busy           <= busy_next;
      pending_count  <= pending_next;
      data_out_debug <= registers[read_address_debug];
    end
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the CPU register file: generic depth and width, same-cycle write-to-read bypass, optional hardwired zero register, registered debug read port, and a per-register busy scoreboard.
Sits between decode/issue and writeback in the pipelined datapath. Issue marks destinations busy; writeback writes data and clears busy. The block reports read-after-write hazards so issue can stall.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads 0, is never written, and is never busy

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-low; sampled on posedge clock
read_address_1  input  ADDR_WIDTH  read port 1 address
read_address_2  input  ADDR_WIDTH  read port 2 address
read_use_1  input  1  port 1 source is consumed by the instruction being issued
read_use_2  input  1  port 2 source is consumed by the instruction being issued
data_out_1  output  DATA_WIDTH  port 1 data (combinational)
data_out_2  output  DATA_WIDTH  port 2 data (combinational)
write_enable  input  1  writeback valid
write_address  input  ADDR_WIDTH  writeback destination
write_data_in  input  DATA_WIDTH  writeback data
issue_valid  input  1  instruction issues this cycle
issue_dest_valid  input  1  issued instruction writes a register
issue_dest  input  ADDR_WIDTH  issued destination
stall  output  1  hazard; issue must hold
pending_count  output  ADDR_WIDTH+1  number of busy registers
read_address_debug  input  ADDR_WIDTH  debug address
data_out_debug  output  DATA_WIDTH  registered debug data

Behaviour:
- Reset (reset==0 at posedge): all registers, busy bits, pending_count and data_out_debug become 0. Reset dominates every other input that cycle.
- Write: at posedge, if write_enable, Registers[write_address] <= write_data_in. Ignored when ZERO_REG and write_address==0.
- Read: combinational. data_out_n = write_data_in when write_enable and write_address==read_address_n (excluding reg 0 when ZERO_REG); otherwise Registers[read_address_n].
  - With ZERO_REG, address 0 always reads 0.
- Scoreboard: busy[DEPTH] bits.
  - Set at posedge when issue_valid & issue_dest_valid & ~stall (never for reg 0 when ZERO_REG).
  - Cleared at posedge when write_enable on write_address.
  - Same register set and cleared in one cycle: set wins (a new producer is issued after the old writeback).
- Effective busy for hazard detection: eff_busy_n = busy[read_address_n] & ~(write_enable & write_address==read_address_n). A writeback in flight bypasses, so no stall.
- stall = issue_valid & ((read_use_1 & eff_busy_1) | (read_use_2 & eff_busy_2) | (issue_dest_valid & eff_busy[issue_dest])).
  - The last term is a WAW hazard: the destination is still pending.
  - Combinational; 0 when issue_valid==0.
- pending_count: registered popcount of busy.
  - +1 on set, -1 on clear, net 0 when both happen to different registers.
  - Set+clear on the same register is net +0 relative to the prior count, since the bit stays 1.
  - Clearing an already-clear bit does not decrement. Never wraps; maximum DEPTH (or DEPTH-1 with ZERO_REG).
- Debug: data_out_debug <= Registers[read_address_debug] each posedge. One-cycle latency, no bypass.
- Reset mid-operation: every pending busy bit is dropped. Writes and issues in the reset cycle are discarded.

Test Plan:
1. Reset low 1 cycle, then read every address on both ports -> 0; pending_count=0; stall=0; data_out_debug=0 one cycle later.
2. write_enable=1, write_address=5, write_data_in=0xDEADBEEF, read_address_1=5 in the same cycle -> data_out_1=0xDEADBEEF combinationally; next cycle still 0xDEADBEEF with write_enable=0; debug read of address 5 returns it one cycle after the address is applied.
3. Write 0x1234 to address 0 (ZERO_REG=1) -> data_out_1 at address 0 stays 0; issue with issue_dest=0 -> busy unchanged, pending_count unchanged.
4. Issue dest 7 (pending_count->1); next cycle issue with read_address_2=7, read_use_2=1 -> stall=1, pending_count=1. Then write_enable to address 7 with 0xA5 in the same cycle as the issue -> stall=0, data_out_2=0xA5, pending_count->0.
5. Busy reg 3; in one cycle write_enable to 3 and issue dest 3 with no other hazard -> stall=0, busy[3] stays 1, pending_count stays 1. A following writeback to 3 -> pending_count=0.
6. Busy regs 2, 4 and 9 (pending_count=3), then assert reset for one cycle while an issue to dest 10 is requested -> pending_count=0, no busy bits set, all registers 0.
